// File: rtl/nano_mem_responder.sv
// Memory-side responder for the NanoCPU bus: 256x16 word store that is filled by a
// valid/ready program loader while the CPU is held, then serves CPU reads/writes in RUN.
module nano_mem_responder #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 2**AW
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] dataW,
  input  logic          ce,
  input  logic          we,
  output logic [DW-1:0] dataR,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          ld_start,
  output logic          ld_ready,
  output logic          cpu_hold,
  output logic [AW:0]   ld_count,
  output logic          bus_err
);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   ld_count_q, ld_count_d;
  logic          bus_err_q, bus_err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          in_load, in_run;
  logic          ld_xfer, cpu_wr, ld_full;
  logic [AW:0]   cnt_inc;

  assign in_load = (state_q == S_LOAD);
  assign in_run  = (state_q == S_RUN);
  assign ld_xfer = in_load & ld_valid;
  assign cpu_wr  = in_run & ce & we;
  assign cnt_inc = ld_count_q + 1'b1;
  assign ld_full = (cnt_inc == DEPTH_C);

  // State register and loader bookkeeping
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      ld_count_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state logic; the DEPTH-th word forces RUN so the count never wraps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: if (ld_xfer && (ld_last || ld_full)) state_d = S_RUN;
      S_RUN:  if (ld_start)                        state_d = S_LOAD;
      default:                                     state_d = S_LOAD;
    endcase
  end

  always_comb begin
    ld_count_d = ld_count_q;
    if (ld_xfer)
      ld_count_d = cnt_inc;
    else if (in_run && ld_start)
      ld_count_d = '0;
  end

  // Any CPU access while it should be held is a protocol error, sticky until reset
  assign bus_err_d = bus_err_q | (in_load & ce);

  // Output logic
  always_comb begin
    ld_ready = in_load;
    cpu_hold = in_load;
    ld_count = ld_count_q;
    bus_err  = bus_err_q;
    dataR    = '0;
    if (in_run && ce) dataR = mem_q[address];
  end

  // Storage is intentionally not reset. Loader and CPU writes are mutually
  // exclusive by state, so a write coinciding with ld_start still lands.
  always_ff @(posedge ck) begin
    if (ld_xfer)
      mem_q[ld_count_q[AW-1:0]] <= ld_data;
    else if (cpu_wr)
      mem_q[address] <= dataW;
  end

endmodule

// File: tb/tb_nano_mem_responder.sv
// Directed bench for nano_mem_responder: a reference memory model feeds an expected-data
// queue that is drained as the DUT presents read data.
module tb_nano_mem_responder;
  localparam int AW = 8, DW = 16, DEPTH = 256;

  logic          ck = 1'b0, rst = 1'b0;
  logic [AW-1:0] address;
  logic [DW-1:0] dataW, ld_data, dataR;
  logic          ce, we, ld_valid, ld_last, ld_start;
  logic          ld_ready, cpu_hold, bus_err;
  logic [AW:0]   ld_count;

  nano_mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .ck(ck), .rst(rst), .address(address), .dataW(dataW), .ce(ce), .we(we),
    .dataR(dataR), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_start(ld_start), .ld_ready(ld_ready), .cpu_hold(cpu_hold),
    .ld_count(ld_count), .bus_err(bus_err)
  );

  always #5 ck = ~ck;

  int            checks = 0, errors = 0;
  logic [DW-1:0] mdl_mem [DEPTH];
  logic          mdl_load;
  int            mdl_cnt;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck); #1;
  endtask

  task automatic idle_in();
    ce = 0; we = 0; ld_valid = 0; ld_last = 0; ld_start = 0;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    tick();
    if (mdl_load) begin
      mdl_mem[mdl_cnt] = d;
      mdl_cnt++;
      if (last || mdl_cnt == DEPTH) mdl_load = 0;
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic cpu_read(input string tag, input logic [AW-1:0] a);
    exp_q.push_back(mdl_load ? 16'h0000 : mdl_mem[a]);
    ce = 1; we = 0; address = a; #1;
    check(tag, dataR, exp_q.pop_front());
    tick();
    ce = 0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ce = 1; we = 1; address = a; dataW = d;
    tick();
    if (!mdl_load) mdl_mem[a] = d;
    ce = 0; we = 0;
  endtask

  task automatic pulse_start();
    ld_start = 1;
    tick();
    ld_start = 0;
    if (!mdl_load) begin mdl_load = 1; mdl_cnt = 0; end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    idle_in(); address = '0; dataW = '0; ld_data = '0;
    mdl_load = 1; mdl_cnt = 0;
    #12;
    check("rst_ready",  ld_ready, 1);
    check("rst_hold",   cpu_hold, 1);
    check("rst_berr",   bus_err,  0);
    check("rst_count",  ld_count, 0);
    check("rst_dataR",  dataR,    0);
    rst = 1;

    // 1: short program terminated by ld_last
    load_word(16'h0012, 0);
    load_word(16'h1034, 0);
    check("t1_hold_mid", cpu_hold, 1);
    load_word(16'h8000, 1);
    check("t1_count", ld_count, 3);
    check("t1_hold",  cpu_hold, 0);
    check("t1_ready", ld_ready, 0);

    // 2: zero-latency reads, ce gating
    cpu_read("t2_rd1", 8'h01);
    cpu_read("t2_rd0", 8'h00);
    ce = 0; address = 8'h01; #1;
    check("t2_ce0", dataR, 0);

    // 3: write then read-old/read-new
    cpu_write(8'h40, 16'h1111);
    ce = 1; we = 1; address = 8'h40; dataW = 16'hBEEF;
    exp_q.push_back(mdl_mem[8'h40]); #1;
    check("t3_old", dataR, exp_q.pop_front());
    tick();
    mdl_mem[8'h40] = 16'hBEEF;
    ce = 0; we = 0;
    cpu_read("t3_new", 8'h40);

    // 4: full-depth load with no ld_last
    pulse_start();
    check("t4_hold", cpu_hold, 1);
    check("t4_cnt0", ld_count, 0);
    check("t4_rdy",  ld_ready, 1);
    for (int i = 0; i < DEPTH; i++) begin
      load_word(DW'(i * 37 + 16'h3000), 0);
      if (i == DEPTH - 2) begin
        check("t4_cnt255", ld_count, 255);
        check("t4_rdy255", ld_ready, 1);
      end
    end
    check("t4_cnt",  ld_count, 9'h100);
    check("t4_rdyF", ld_ready, 0);
    check("t4_run",  cpu_hold, 0);
    load_word(16'hFFFF, 1);
    check("t4_cnt_run", ld_count, 9'h100);
    cpu_read("t4_w0",   8'h00);
    cpu_read("t4_w128", 8'h80);
    cpu_read("t4_w255", 8'hFF);

    // 5: reset mid-load restarts at word 0
    pulse_start();
    for (int i = 0; i < 5; i++) load_word(DW'(16'hA000 + i), 0);
    rst = 0; #3;
    check("t5_rst_cnt",  ld_count, 0);
    check("t5_rst_hold", cpu_hold, 1);
    rst = 1; mdl_load = 1; mdl_cnt = 0;
    for (int i = 0; i < 10; i++) load_word(DW'(16'hC000 + i), i == 9);
    check("t5_cnt", ld_count, 10);
    for (int i = 0; i < 11; i++) cpu_read($sformatf("t5_w%0d", i), AW'(i));

    // 6: ld_start with a same-cycle write, then illegal CPU access in LOAD
    ce = 1; we = 1; address = 8'h20; dataW = 16'h7777; ld_start = 1;
    tick();
    mdl_mem[8'h20] = 16'h7777; mdl_load = 1; mdl_cnt = 0;
    idle_in();
    check("t6_hold", cpu_hold, 1);
    check("t6_berr0", bus_err, 0);
    ce = 1; we = 1; address = 8'h21; dataW = 16'hDEAD;
    exp_q.push_back(16'h0000); #1;
    check("t6_ld_rd", dataR, exp_q.pop_front());
    tick();
    idle_in();
    check("t6_berr1", bus_err, 1);
    tick(); tick(); tick();
    check("t6_sticky", bus_err, 1);
    load_word(16'h1234, 1);
    check("t6_run", cpu_hold, 0);
    check("t6_berr_run", bus_err, 1);
    cpu_read("t6_w21", 8'h21);
    cpu_read("t6_w20", 8'h20);
    cpu_read("t6_w0",  8'h00);
    rst = 0; #1;
    check("t6_berr_rst", bus_err, 0);
    rst = 1;

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
